comparador_histeresis: RTL and testbench
========================================

Name: comparador_histeresis

Overview:
- Multi-channel temperature threshold monitor; parametrised successor to the single-bit "D >= A" temperature comparator.
- Per channel it adds hysteresis (separate assert/clear levels) and a debounce counter, so a reading must hold for DEB consecutive samples before the alarm changes.
- Sits between the sensor sampling logic and the fan/alarm control. It provides registered alarm levels and one-cycle change pulses for the control FSM.

Parameters:
N, 5, bit width of every temperature value and threshold (unsigned).
CH, 2, number of independent temperature channels.
DEB, 3, consecutive qualifying samples required to change alarm state (legal range 1..15).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
sample_en  input  1  one-cycle strobe marking a valid sample on temp; the block ignores temp when this is low.
temp  input  CH*N  packed readings; channel k uses bits [k*N+N-1 : k*N].
set_pt  input  N  assert threshold, shared by all channels.
hyst  input  N  hysteresis width, shared by all channels.
alarm  output  CH  registered alarm level per channel.
alarm_any  output  1  registered OR of all alarm bits.
rise_evt  output  CH  one-cycle pulse when alarm[k] goes 0->1.
fall_evt  output  CH  one-cycle pulse when alarm[k] goes 1->0.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All channels enter OFF with the counter at 0.
  - alarm, alarm_any, rise_evt and fall_evt are all 0.
  - Deassertion takes effect at the next clk edge. Reset during ARMING or DISARMING discards the partial count.
- Threshold arithmetic, evaluated each sample with the current set_pt/hyst values:
  - hi_q = (temp_k >= set_pt). Equality counts as "hot".
  - clr_lvl = set_pt - hyst, saturating at 0.
  - lo_q = (temp_k < clr_lvl).
  - If hyst >= set_pt, then clr_lvl = 0, lo_q is never true, and an asserted alarm stays latched until reset.
  - hyst = 0 means the clear condition is temp_k < set_pt.
- Per-channel FSM states: OFF, ARMING, ON, DISARMING. Counter width is 4 bits.
  - Transitions happen only on cycles with sample_en=1. With sample_en=0, state and counter hold.
  - OFF: if hi_q, cnt=1. If DEB=1, go straight to ON; otherwise go to ARMING.
  - ARMING:
    - hi_q: cnt+1. When cnt+1 == DEB, go to ON and clear cnt.
    - !hi_q: return to OFF and clear cnt. The sample does not need to satisfy lo_q to abort.
  - ON: if lo_q, cnt=1. If DEB=1, go straight to OFF; otherwise go to DISARMING.
  - DISARMING:
    - lo_q: cnt+1. When cnt+1 == DEB, go to OFF and clear cnt.
    - !lo_q: return to ON and clear cnt.
- Outputs and timing:
  - alarm[k] = 1 in ON and DISARMING; 0 in OFF and ARMING. It is registered and changes on the same edge as the state transition.
  - Latency: alarm[k] rises on the clk edge that samples the DEB-th consecutive qualifying sample.
  - rise_evt/fall_evt are registered, high for exactly the one cycle following that edge, and never both high on the same channel.
  - alarm_any is registered and updates on the same edge as alarm.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Mid-operation changes to set_pt or hyst apply to the next sample only. Partial counts are not reset by them.

Test Plan:
- Reset and idle: hold reset_n=0 with temp=all 31. Expect alarm=0, alarm_any=0, no events. Release reset and keep sample_en=0 for 10 cycles: outputs stay 0.
- Debounced assert (N=5, DEB=3, set_pt=20, hyst=4): ch0 samples 20,21,22 -> alarm[0]=1 and rise_evt[0] pulses once, right after the 3rd sample edge. ch1 held at 10 -> alarm[1]=0 throughout.
- Glitch rejection: ch0 samples 25,25,15,25,25 -> alarm[0] stays 0 (count restarts at the 15). A further sample of 25 -> alarm[0]=1.
- Hysteresis band (set_pt=20, hyst=4, alarm ON): three samples of 17 -> alarm stays 1. Three samples of 15 -> fall_evt[0] pulses and alarm[0]=0.
- Saturation and latch (set_pt=3, hyst=5): assert with 3,3,3, then 20 samples of 0 -> alarm stays 1. Pulse reset_n low mid-DISARMING with set_pt=20 -> all outputs 0 immediately, without waiting for clk.
- Simultaneous channels, DEB=1 build: both channels sample 31 in one strobe -> alarm=2'b11 and rise_evt=2'b11 for one cycle, alarm_any=1 on the same edge.

Source files
------------

// File: rtl/comparador_histeresis.sv
// Multi-channel temperature alarm with hysteresis and per-channel debounce.
// Shared threshold arithmetic feeds an array of identical channel FSMs.

module comparador_histeresis_ch #(
  parameter int DEB = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic hi_q,
  input  logic lo_q,
  output logic alarm_d,
  output logic alarm,
  output logic rise_evt,
  output logic fall_evt
);
  typedef enum logic [1:0] {OFF, ARMING, ON, DISARMING} st_t;

  localparam logic [3:0] DEB_C = 4'(DEB);

  st_t        st, st_n;
  logic [3:0] cnt, cnt_n, cnt_inc;

  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (sample_en) begin
      unique case (st)
        OFF: if (hi_q) begin
          if (DEB_C == 4'd1) begin st_n = ON; cnt_n = '0; end
          else begin st_n = ARMING; cnt_n = 4'd1; end
        end
        ARMING: begin
          if (!hi_q) begin st_n = OFF; cnt_n = '0; end
          else if (cnt_inc == DEB_C) begin st_n = ON; cnt_n = '0; end
          else cnt_n = cnt_inc;
        end
        ON: if (lo_q) begin
          if (DEB_C == 4'd1) begin st_n = OFF; cnt_n = '0; end
          else begin st_n = DISARMING; cnt_n = 4'd1; end
        end
        DISARMING: begin
          if (!lo_q) begin st_n = ON; cnt_n = '0; end
          else if (cnt_inc == DEB_C) begin st_n = OFF; cnt_n = '0; end
          else cnt_n = cnt_inc;
        end
        default: begin st_n = OFF; cnt_n = '0; end
      endcase
    end
    alarm_d = (st_n == ON) || (st_n == DISARMING);
  end

  // Edge pulses come from comparing next alarm against current, so they
  // land exactly one cycle after the transition edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= OFF;
      cnt      <= '0;
      alarm    <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      alarm    <= alarm_d;
      rise_evt <= alarm_d & ~alarm;
      fall_evt <= ~alarm_d & alarm;
    end
  end
endmodule

module comparador_histeresis #(
  parameter int N   = 5,
  parameter int CH  = 2,
  parameter int DEB = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_en,
  input  logic [CH*N-1:0] temp,
  input  logic [N-1:0]    set_pt,
  input  logic [N-1:0]    hyst,
  output logic [CH-1:0]   alarm,
  output logic            alarm_any,
  output logic [CH-1:0]   rise_evt,
  output logic [CH-1:0]   fall_evt
);
  logic [CH-1:0][N-1:0] temp_a;
  logic [N-1:0]         clr_lvl;
  logic [CH-1:0]        hi, lo, alarm_d;

  assign temp_a = temp;

  // Saturating clear level: a band wider than set_pt latches the alarm.
  assign clr_lvl = (hyst >= set_pt) ? '0 : set_pt - hyst;

  for (genvar k = 0; k < CH; k++) begin : g_qual
    assign hi[k] = temp_a[k] >= set_pt;
    assign lo[k] = temp_a[k] < clr_lvl;
  end

  comparador_histeresis_ch #(.DEB(DEB)) u_ch [CH-1:0] (
    .clk      (clk),
    .reset_n  (reset_n),
    .sample_en(sample_en),
    .hi_q     (hi),
    .lo_q     (lo),
    .alarm_d  (alarm_d),
    .alarm    (alarm),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alarm_any <= 1'b0;
    else          alarm_any <= |alarm_d;
  end
endmodule

// File: tb/tb_comparador_histeresis.sv
// Checks a DEB=3 and a DEB=1 build against a run-length alarm model.
module tb_comparador_histeresis;
  localparam int N  = 5;
  localparam int CH = 2;
  localparam int DEBS [2] = '{3, 1};

  logic            clk = 1'b0;
  logic            reset_n;
  logic            sample_en;
  logic [CH*N-1:0] temp;
  logic [N-1:0]    set_pt, hyst;

  logic [CH-1:0] a3, r3, f3, a1, r1, f1;
  logic          any3, any1;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  logic [CH-1:0] m_al [2];
  logic [CH-1:0] m_ri [2];
  logic [CH-1:0] m_fa [2];
  int            m_run [2][CH];

  always #5 clk = ~clk;

  comparador_histeresis #(.N(N), .CH(CH), .DEB(3)) u3 (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .temp(temp),
    .set_pt(set_pt), .hyst(hyst), .alarm(a3), .alarm_any(any3),
    .rise_evt(r3), .fall_evt(f3));

  comparador_histeresis #(.N(N), .CH(CH), .DEB(1)) u1 (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .temp(temp),
    .set_pt(set_pt), .hyst(hyst), .alarm(a1), .alarm_any(any1),
    .rise_evt(r1), .fall_evt(f1));

  task automatic chk2(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_al[d] = '0; m_ri[d] = '0; m_fa[d] = '0;
      for (int k = 0; k < CH; k++) m_run[d][k] = 0;
    end
  endtask

  // Alarm flips once DEB consecutive strobed samples qualify for the
  // opposite level; any non-qualifying sample restarts the run.
  task automatic model_update();
    logic [N-1:0]  t, clr;
    logic          q;
    logic [CH-1:0] prev;
    if (!reset_n) begin model_clear(); return; end
    clr = (set_pt > hyst) ? set_pt - hyst : '0;
    for (int d = 0; d < 2; d++) begin
      prev = m_al[d];
      if (sample_en) begin
        for (int k = 0; k < CH; k++) begin
          t = temp[k*N +: N];
          q = m_al[d][k] ? (t < clr) : (t >= set_pt);
          m_run[d][k] = q ? m_run[d][k] + 1 : 0;
          if (m_run[d][k] == DEBS[d]) begin
            m_al[d][k]  = ~m_al[d][k];
            m_run[d][k] = 0;
          end
        end
      end
      m_ri[d] = ~prev & m_al[d];
      m_fa[d] = prev & ~m_al[d];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk2("alarm3", a3, m_al[0]);
      chk1("any3", any3, |m_al[0]);
      chk2("rise3", r3, m_ri[0]);
      chk2("fall3", f3, m_fa[0]);
      chk2("alarm1", a1, m_al[1]);
      chk1("any1", any1, |m_al[1]);
      chk2("rise1", r1, m_ri[1]);
      chk2("fall1", f1, m_fa[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic sample(input logic [N-1:0] t0, input logic [N-1:0] t1);
    temp      = {t1, t0};
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic async_reset(input bit lit);
    #3 reset_n = 1'b0;
    model_clear();
    #1;
    if (lit) begin
      chk2("async_alarm", a3, 2'b00);
      chk1("async_any", any3, 1'b0);
      chk2("async_rise", r3, 2'b00);
      chk2("async_fall", f3, 2'b00);
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; sample_en = 1'b0; temp = '1; set_pt = 5'd20; hyst = 5'd4;
    model_clear();
    #12;
    chk2("rst_alarm", a3, 2'b00);
    chk1("rst_any", any3, 1'b0);
    chk2("rst_rise", r3 | f3, 2'b00);
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk2("idle_alarm", a3, 2'b00);
    chk1("idle_any", any3, 1'b0);

    // Debounced assert
    sample(20, 10); sample(21, 10);
    chk1("arm_not_yet", a3[0], 1'b0);
    sample(22, 10);
    chk1("assert_alarm0", a3[0], 1'b1);
    chk1("assert_rise0", r3[0], 1'b1);
    chk1("assert_alarm1", a3[1], 1'b0);
    tick();
    chk1("rise_one_cycle", r3[0], 1'b0);

    // Hysteresis band: 17 sits inside [16,20), 15 clears
    repeat (3) sample(17, 10);
    chk1("band_hold", a3[0], 1'b1);
    sample(15, 10); sample(15, 10);
    chk1("disarm_not_yet", a3[0], 1'b1);
    sample(15, 10);
    chk1("clear_alarm0", a3[0], 1'b0);
    chk1("clear_fall0", f3[0], 1'b1);

    // Glitch rejection
    sample(25, 10); sample(25, 10); sample(15, 10); sample(25, 10); sample(25, 10);
    chk1("glitch_hold", a3[0], 1'b0);
    sample(25, 10);
    chk1("glitch_then_on", a3[0], 1'b1);
    repeat (3) sample(0, 0);
    chk1("cleared_again", a3[0], 1'b0);

    // Saturated clear level latches the alarm
    set_pt = 5'd3; hyst = 5'd5;
    repeat (3) sample(3, 0);
    chk1("sat_on", a3[0], 1'b1);
    repeat (20) sample(0, 0);
    chk1("sat_latched", a3[0], 1'b1);
    set_pt = 5'd20;
    sample(0, 0);
    chk1("disarming_alarm", a3[0], 1'b1);
    async_reset(1'b1);
    tick();

    // Simultaneous channels on the DEB=1 build
    set_pt = 5'd20; hyst = 5'd4;
    sample(31, 31);
    chk2("deb1_alarm", a1, 2'b11);
    chk2("deb1_rise", r1, 2'b11);
    chk1("deb1_any", any1, 1'b1);
    chk2("deb3_still_off", a3, 2'b00);
    tick();
    chk2("deb1_rise_drop", r1, 2'b00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        set_pt = 5'($urandom_range(0, 31));
        hyst   = 5'($urandom_range(0, 12));
      end
      sample_en = ($urandom_range(0, 3) != 0);
      temp      = 10'($urandom);
      tick();
      if ($urandom_range(0, 399) == 0) async_reset(1'b0);
    end
    sample_en = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
